// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the MAC job sequencer.
package mac_seq_pkg;

    // Default width of the job length field (max job = 2^LEN_W-1 products).
    localparam int unsigned LEN_W_DEFAULT  = 5;
    // Default operand buffer address width; must be >= LEN_W.
    localparam int unsigned ADDR_W_DEFAULT = 5;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StHold
    } state_e;

endpackage

// File: rtl/mac_seq_valid_pipe.sv
// Two-stage valid shift register that tracks products in flight through the
// multiply register (v1) and the accumulator (v2). It never stalls; bubbles
// simply shift through.
module mac_seq_valid_pipe (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic v1,
    output logic v2
);

    logic v1_q;
    logic v2_q;

    // Shift the issue strobe through both stages; reset discards in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= din;
            v2_q <= v1_q;
        end
    end

    assign v1 = v1_q;
    assign v2 = v2_q;

endmodule

// File: rtl/mac_sequencer.sv
// Sequences one dot-product job through the two-stage multiply/accumulate
// pipeline: fetches len operand pairs, inserts bubbles when operands are
// missing, drains the pipe and holds the result under valid/ready.
// Optional build macro MAC_SEQUENCER_PERF_EN adds stall_cnt / job_cycles
// performance counters.
module mac_sequencer
    import mac_seq_pkg::*;
#(
    parameter int unsigned LEN_W  = LEN_W_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              op_valid,
    input  logic              out_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              clr_acc,
    output logic              ld_mult,
    output logic              ld_add,
    output logic              pipe_stall,
    output logic              busy,
    output logic              out_valid,
`ifdef MAC_SEQUENCER_PERF_EN
    output logic [15:0]       stall_cnt,
    output logic [15:0]       job_cycles,
`endif
    output logic              done
);

    state_e           state_q;
    state_e           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] issued_q;
    logic             clr_acc_q;
    logic             done_q;
    logic             v1;
    logic             v2;
    logic             issue;
    logic             accept;
    logic             last_issue;

    // Start is only honoured in IDLE; a zero-length job never leaves IDLE.
    assign accept     = (state_q == StIdle) && start;
    assign issue      = (state_q == StRun) && op_valid && (issued_q < len_q);
    assign last_issue = issue && ((issued_q + LEN_W'(1)) == len_q);

    mac_seq_valid_pipe u_valid_pipe (
        .clk (clk),
        .rst (rst),
        .din (issue),
        .v1  (v1),
        .v2  (v2)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && (len != '0)) state_d = StRun;
            StRun:   if (last_issue)            state_d = StDrain;
            // Once v1 is empty the final accumulate is happening this cycle.
            StDrain: if (!v1)                   state_d = StHold;
            StHold:  if (out_ready)             state_d = StIdle;
            default:                            state_d = StIdle;
        endcase
    end

    // Job bookkeeping: latched length, issue count and registered pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            issued_q  <= '0;
            clr_acc_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            clr_acc_q <= accept && (len != '0);
            done_q    <= (accept && (len == '0)) || ((state_q == StHold) && out_ready);
            if (accept && (len != '0)) begin
                len_q    <= len;
                issued_q <= '0;
            end else if (issue) begin
                issued_q <= issued_q + LEN_W'(1);
            end
        end
    end

    // Output decode from registered state; rd_en/pipe_stall also follow op_valid.
    always_comb begin
        rd_en      = issue;
        rd_addr    = ADDR_W'(issued_q);
        pipe_stall = (state_q == StRun) && !op_valid;
        clr_acc    = clr_acc_q;
        ld_mult    = v1;
        ld_add     = v2;
        busy       = (state_q != StIdle);
        out_valid  = (state_q == StHold);
        done       = done_q;
    end

`ifdef MAC_SEQUENCER_PERF_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] job_cycles_q;

    // Saturating performance counters, cleared on an accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            job_cycles_q <= '0;
        end else if (accept) begin
            stall_cnt_q  <= '0;
            job_cycles_q <= '0;
        end else begin
            if (pipe_stall && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if ((state_q != StIdle) && (job_cycles_q != 16'hFFFF)) begin
                job_cycles_q <= job_cycles_q + 16'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign job_cycles = job_cycles_q;
`endif

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: each directed job pushes the expected
// cycle of every output pulse into per-signal queues; a negedge monitor pops
// and compares whenever the DUT asserts a signal.
`define CHK_EVT(NAME, SIG, Q) \
    if (SIG) begin \
        checks++; \
        if (Q.size() == 0) begin \
            failures++; \
            $display("FAIL %s: asserted at cycle %0d, expected no assertion", NAME, cyc); \
        end else begin \
            exp_c = Q.pop_front(); \
            if (exp_c != cyc) begin \
                failures++; \
                $display("FAIL %s: asserted at cycle %0d, expected cycle %0d", NAME, cyc, exp_c); \
            end \
        end \
    end

module tb_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] len;
    logic       op_valid;
    logic       out_ready;
    logic       rd_en;
    logic [4:0] rd_addr;
    logic       clr_acc;
    logic       ld_mult;
    logic       ld_add;
    logic       pipe_stall;
    logic       busy;
    logic       out_valid;
    logic       done;
`ifdef MAC_SEQUENCER_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] job_cycles;
`endif

    mac_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .op_valid   (op_valid),
        .out_ready  (out_ready),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .clr_acc    (clr_acc),
        .ld_mult    (ld_mult),
        .ld_add     (ld_add),
        .pipe_stall (pipe_stall),
        .busy       (busy),
        .out_valid  (out_valid),
`ifdef MAC_SEQUENCER_PERF_EN
        .stall_cnt  (stall_cnt),
        .job_cycles (job_cycles),
`endif
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int exp_c;
    int exp_a;
    bit mon_en = 1'b0;

    int clr_q[$];
    int rd_q[$];
    int addr_q[$];
    int ldm_q[$];
    int lda_q[$];
    int stall_q[$];
    int busy_q[$];
    int ov_q[$];
    int done_q[$];

    // Monitor: compare every asserted output against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            `CHK_EVT("clr_acc", clr_acc, clr_q)
            `CHK_EVT("ld_mult", ld_mult, ldm_q)
            `CHK_EVT("ld_add", ld_add, lda_q)
            `CHK_EVT("pipe_stall", pipe_stall, stall_q)
            `CHK_EVT("busy", busy, busy_q)
            `CHK_EVT("out_valid", out_valid, ov_q)
            `CHK_EVT("done", done, done_q)
            if (rd_en) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_en: asserted at cycle %0d addr %0d, expected no read",
                             cyc, rd_addr);
                end else begin
                    exp_c = rd_q.pop_front();
                    exp_a = addr_q.pop_front();
                    if (exp_c != cyc || exp_a != int'(rd_addr)) begin
                        failures++;
                        $display("FAIL rd_en: cycle %0d addr %0d, expected cycle %0d addr %0d",
                                 cyc, rd_addr, exp_c, exp_a);
                    end
                end
            end
        end
    end

    // which: 0 clr, 1 ld_mult, 2 ld_add, 3 stall, 4 busy, 5 out_valid, 6 done
    task automatic push(input int which, input int from, input int to);
        for (int c = from; c <= to; c++) begin
            case (which)
                0: clr_q.push_back(c);
                1: ldm_q.push_back(c);
                2: lda_q.push_back(c);
                3: stall_q.push_back(c);
                4: busy_q.push_back(c);
                5: ov_q.push_back(c);
                default: done_q.push_back(c);
            endcase
        end
    endtask

    task automatic push_rd(input int c, input int a);
        rd_q.push_back(c);
        addr_q.push_back(a);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one job: relative cycle 0 is the start cycle.
    task automatic run(input int n, input logic [31:0] stall_mask, input int ready_low_until,
                       input int restart_rel, input int restart_len, input int rst_rel,
                       input int total);
        for (int rel = 0; rel < total; rel++) begin
            start     = (rel == 0) || (rel == restart_rel);
            len       = (rel == restart_rel) ? 5'(restart_len) : 5'(n);
            op_valid  = !stall_mask[rel];
            out_ready = (rel > ready_low_until);
            rst       = (rel == rst_rel);
            tick();
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic drained(input string name);
        int pending;
        pending = clr_q.size() + rd_q.size() + ldm_q.size() + lda_q.size() + stall_q.size()
                + busy_q.size() + ov_q.size() + done_q.size();
        checks++;
        if (pending != 0) begin
            failures++;
            $display("FAIL %s: %0d expected events never seen, expected 0", name, pending);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    int b;

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; op_valid = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        check_val("reset rd_en", rd_en, 0);
        check_val("reset rd_addr", rd_addr, 0);
        check_val("reset clr_acc", clr_acc, 0);
        check_val("reset ld_mult", ld_mult, 0);
        check_val("reset ld_add", ld_add, 0);
        check_val("reset pipe_stall", pipe_stall, 0);
        check_val("reset busy", busy, 0);
        check_val("reset out_valid", out_valid, 0);
        check_val("reset done", done, 0);
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // len=4, no stalls, always ready.
        b = cyc;
        push(0, b+1, b+1);
        for (int i = 0; i < 4; i++) push_rd(b+1+i, i);
        push(1, b+2, b+5); push(2, b+3, b+6); push(4, b+1, b+7);
        push(5, b+7, b+7); push(6, b+8, b+8);
        run(4, 32'h0, -1, -1, 0, -1, 11);
        drained("drain_basic");

        // len=4, operands missing at relative cycles 2 and 3.
        b = cyc;
        push(0, b+1, b+1);
        push_rd(b+1, 0); push_rd(b+4, 1); push_rd(b+5, 2); push_rd(b+6, 3);
        push(1, b+2, b+2); push(1, b+5, b+7);
        push(2, b+3, b+3); push(2, b+6, b+8);
        push(3, b+2, b+3); push(4, b+1, b+9);
        push(5, b+9, b+9); push(6, b+10, b+10);
        run(4, 32'b1100, -1, -1, 0, -1, 13);
        drained("drain_stall");
`ifdef MAC_SEQUENCER_PERF_EN
        check_val("stall_cnt", stall_cnt, 2);
        check_val("job_cycles", job_cycles, 9);
`endif

        // len=1, consumer not ready for five HOLD cycles.
        b = cyc;
        push(0, b+1, b+1); push_rd(b+1, 0);
        push(1, b+2, b+2); push(2, b+3, b+3); push(4, b+1, b+9);
        push(5, b+4, b+9); push(6, b+10, b+10);
        run(1, 32'h0, 8, -1, 0, -1, 13);
        drained("drain_backpressure");

        // len=0: immediate done, nothing else.
        b = cyc;
        push(6, b+1, b+1);
        run(0, 32'h0, -1, -1, 0, -1, 4);
        drained("drain_zero_len");

        // len=8 job aborted by reset during relative cycle 3.
        b = cyc;
        push(0, b+1, b+1);
        for (int i = 0; i < 3; i++) push_rd(b+1+i, i);
        push(1, b+2, b+3); push(2, b+3, b+3); push(4, b+1, b+3);
        run(8, 32'h0, -1, -1, 0, 3, 5);
        drained("drain_reset_abort");
        check_val("rd_addr after reset", rd_addr, 0);

        // Fresh len=2 job after the abort; addresses restart at 0.
        b = cyc;
        push(0, b+1, b+1); push_rd(b+1, 0); push_rd(b+2, 1);
        push(1, b+2, b+3); push(2, b+3, b+4); push(4, b+1, b+5);
        push(5, b+5, b+5); push(6, b+6, b+6);
        run(2, 32'h0, -1, -1, 0, -1, 9);
        drained("drain_after_reset");

        // len=3 with a stray start (len=7) during RUN, which must be ignored.
        b = cyc;
        push(0, b+1, b+1);
        for (int i = 0; i < 3; i++) push_rd(b+1+i, i);
        push(1, b+2, b+4); push(2, b+3, b+5); push(4, b+1, b+6);
        push(5, b+6, b+6); push(6, b+7, b+7);
        run(3, 32'h0, -1, 2, 7, -1, 10);
        drained("drain_ignored_start");

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
